// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_res_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row strobing, frame classification, press/release
// debouncing and a single-entry valid/ready event output with overrun flag.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 50_000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic             clk,
    input  logic             rst,
    output logic [KEY_W-1:0] row,
    input  logic [KEY_W-1:0] col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    input  logic             key_ready,
    output logic             key_down,
    output logic             overrun
);

    localparam int TICK_W = $clog2(SCAN_TICKS);
    localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);

    logic [KEY_W-1:0] col_s;

    sync_2ff #(.WIDTH(KEY_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (col),
        .q_o (col_s)
    );

    // Scan timing: run_q holds row drive off until the first edge after reset.
    logic              run_q, run_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic              sample, frame_end;

    assign sample    = run_q && (tick_q == TICK_W'(SCAN_TICKS - 1));
    assign frame_end = sample && (row_idx_q == 2'd3);

    always_comb begin
        run_d     = 1'b1;
        tick_d    = tick_q + TICK_W'(1);
        row_idx_d = row_idx_q;
        if (!run_q) begin
            tick_d    = '0;
            row_idx_d = 2'd0;
        end else if (sample) begin
            tick_d    = '0;
            row_idx_d = row_idx_q + 2'd1;
        end
    end

    // Frame accumulation; row 0 starts from an empty frame.
    logic             acc_any_q, acc_any_d;
    logic             acc_multi_q, acc_multi_d;
    logic [KEY_W-1:0] acc_code_q, acc_code_d;
    logic [3:0]       row_low;
    logic [2:0]       row_cnt;
    logic             base_any, base_multi, cur_any, cur_multi;
    logic [KEY_W-1:0] frame_code;
    frame_res_e       frame_res;

    always_comb begin
        row_low    = ~col_s;
        row_cnt    = popcount4(row_low);
        base_any   = (row_idx_q != 2'd0) && acc_any_q;
        base_multi = (row_idx_q != 2'd0) && acc_multi_q;
        cur_any    = base_any || (row_cnt != 3'd0);
        cur_multi  = base_multi || (row_cnt > 3'd1) || (base_any && (row_cnt != 3'd0));
        frame_code = base_any ? acc_code_q : {row_idx_q, low_index(row_low)};
        frame_res  = cur_multi ? FR_MULTI : (cur_any ? FR_SINGLE : FR_NONE);
        acc_any_d   = sample ? cur_any    : acc_any_q;
        acc_multi_d = sample ? cur_multi  : acc_multi_q;
        acc_code_d  = sample ? frame_code : acc_code_q;
    end

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [KEY_W-1:0] cand_q, cand_d;
    logic             emit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        emit    = 1'b0;
        cnt_inc = cnt_q + CNT_W'(1);
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_res == FR_SINGLE) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE_FRAMES == 1) begin
                            state_d = ST_HELD;
                            emit    = 1'b1;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end
                end
                ST_PRESS_DB: begin
                    if (frame_res == FR_SINGLE && frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
                            state_d = ST_HELD;
                            emit    = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (frame_res == FR_NONE) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (DEBOUNCE_FRAMES == 1) ? ST_IDLE : ST_RELEASE_DB;
                    end
                end
                ST_RELEASE_DB: begin
                    if (frame_res == FR_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output slot: a new event is dropped rather than overwriting an unconsumed one.
    logic             valid_q, valid_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovr_d   = 1'b0;
        if (emit) begin
            if (!valid_q || key_ready) begin
                valid_d = 1'b1;
                code_d  = frame_code;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && key_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q       <= 1'b0;
            tick_q      <= '0;
            row_idx_q   <= 2'd0;
            acc_any_q   <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            valid_q     <= 1'b0;
            code_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            run_q       <= run_d;
            tick_q      <= tick_d;
            row_idx_q   <= row_idx_d;
            acc_any_q   <= acc_any_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            valid_q     <= valid_d;
            code_q      <= code_d;
            ovr_q       <= ovr_d;
        end
    end

    assign row       = run_q ? ~(4'b0001 << row_idx_q) : 4'b1111;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign overrun   = ovr_q;
    assign key_down  = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);

endmodule
